// File: rtl/row_uram_loader.sv
// row_uram_loader: AXI4-Stream int16 row beats -> one-hot URAM write strobes, address and data.
// Latency: start->first tready 1 cycle; accepted beat appears on URAM ports next cycle; last accept->done 2 cycles.
// Backpressure: tready is high for the whole LOAD state only; the URAMs never stall, tvalid gaps stall the counters.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, num_pairs_m1  begin a load of num_pairs_m1+1 row-pairs (16 beats each); honoured only in IDLE
//   s_axis_*             64-bit input stream, tlast marks the final beat of the load
//   busy, done           busy in LOAD/DONE; done pulses one cycle after the last write has been issued
//   tlast_err            sticky tlast position mismatch, cleared by an honoured start
//   uram_ena/wea/addra/dina  write port fan-out to 4 sets x 16 URAMs
module row_uram_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_SETS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH+1:0] num_pairs_m1,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [63:0]           s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  tlast_err,
  output logic [63:0]           uram_ena,
  output logic [63:0]           uram_wea,
  output logic [ADDR_WIDTH-1:0] uram_addra,
  output logic [63:0]           uram_dina
);

  localparam int SET_BITS = $clog2(NUM_SETS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]            r_beat_cnt;
  logic [ADDR_WIDTH+1:0] r_pair_cnt;
  logic [ADDR_WIDTH+1:0] r_num_pairs_m1;
  logic                  r_tlast_err;
  logic                  r_done;
  logic [63:0]           r_ena;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [63:0]           r_dina;

  logic                  w_start_ok;
  logic                  w_accept;
  logic                  w_final;
  logic [5:0]            w_wr_idx;

  assign w_accept = s_axis_tvalid & s_axis_tready;
  assign w_final  = (r_beat_cnt == 4'd15) && (r_pair_cnt == r_num_pairs_m1);
  // Set index in the upper bits, URAM-within-set (beat index) in the lower four.
  assign w_wr_idx = {r_pair_cnt[SET_BITS-1:0], r_beat_cnt};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_accept && w_final) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; tready depends on state only, never on tvalid.
  always_comb begin
    s_axis_tready = 1'b0;
    busy          = 1'b0;
    w_start_ok    = 1'b0;
    case (r_state)
      S_IDLE: w_start_ok = start;
      S_LOAD: begin
        s_axis_tready = 1'b1;
        busy          = 1'b1;
      end
      S_DONE: busy = 1'b1;
      default: ;
    endcase
  end

  // Counters and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt     <= '0;
      r_pair_cnt     <= '0;
      r_num_pairs_m1 <= '0;
      r_tlast_err    <= 1'b0;
      r_done         <= 1'b0;
      r_ena          <= '0;
      r_addr         <= '0;
      r_dina         <= '0;
    end else begin
      r_ena  <= '0;
      // done rises on the DONE->IDLE edge, after the last strobe has been on the ports.
      r_done <= (r_state == S_DONE);
      if (w_start_ok) begin
        r_num_pairs_m1 <= num_pairs_m1;
        r_beat_cnt     <= '0;
        r_pair_cnt     <= '0;
        r_tlast_err    <= 1'b0;
      end
      if (w_accept) begin
        r_dina     <= s_axis_tdata;
        r_addr     <= r_pair_cnt[SET_BITS +: ADDR_WIDTH];
        r_ena      <= 64'd1 << w_wr_idx;
        r_beat_cnt <= r_beat_cnt + 4'd1;
        if (r_beat_cnt == 4'd15) begin
          r_pair_cnt <= r_pair_cnt + 1'b1;
        end
        // Flag tlast early or missing; the load keeps going either way.
        if (s_axis_tlast != w_final) begin
          r_tlast_err <= 1'b1;
        end
      end
    end
  end

  assign done       = r_done;
  assign tlast_err  = r_tlast_err;
  assign uram_ena   = r_ena;
  assign uram_wea   = r_ena;
  assign uram_addra = r_addr;
  assign uram_dina  = r_dina;

endmodule

// File: tb/tb_row_uram_loader.sv
// tb_row_uram_loader: directed stimulus with a write scoreboard for row_uram_loader.
// Expected URAM writes are queued by the driver at handshake time and popped by a negedge monitor.
// Stream ready is honoured by the driver; waits are bounded and a timeout counts as a failure.
module tb_row_uram_loader;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW+1:0] num_pairs_m1;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [63:0]   s_axis_tdata;
  logic          s_axis_tlast;
  logic          busy;
  logic          done;
  logic          tlast_err;
  logic [63:0]   uram_ena;
  logic [63:0]   uram_wea;
  logic [AW-1:0] uram_addra;
  logic [63:0]   uram_dina;

  row_uram_loader #(.ADDR_WIDTH(AW), .NUM_SETS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pairs_m1(num_pairs_m1),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .busy(busy), .done(done), .tlast_err(tlast_err),
    .uram_ena(uram_ena), .uram_wea(uram_wea), .uram_addra(uram_addra), .uram_dina(uram_dina)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]   ena;
    logic [AW-1:0] addr;
    logic [63:0]   dat;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] log_ena[$];
  logic [AW-1:0] log_addr[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (uram_ena !== 64'd0) begin
      log_ena.push_back(uram_ena);
      log_addr.push_back(uram_addra);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", uram_ena, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_ena", uram_ena, e.ena);
        chk("wr_wea", uram_wea, e.ena);
        chk("wr_addr", 64'(uram_addra), 64'(e.addr));
        chk("wr_dina", uram_dina, e.dat);
      end
    end
  end

  // Drive one beat with global beat index j; optional tvalid-low gap cycles first.
  task automatic send(input int j, input logic [63:0] d, input logic last, input int gaps);
    int t;
    wr_t e;
    if (gaps > 0) begin
      s_axis_tvalid = 1'b0;
      for (int g = 0; g < gaps; g++) begin
        @(posedge clk);
        @(negedge clk);
        chk("gap_ena_zero", uram_ena, 64'd0);
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (s_axis_tready === 1'b1) break;
      t++;
      if (t > 40) break;
    end
    if (t > 40) begin
      chk("tready_timeout", 64'(s_axis_tready), 64'd1);
    end else begin
      e.ena  = 64'd1 << (((j / 16) % 4) * 16 + (j % 16));
      e.addr = AW'((j / 16) / 4);
      e.dat  = d;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_start(input int npm1);
    chk("pre_start_tready", 64'(s_axis_tready), 64'd0);
    start        = 1'b1;
    num_pairs_m1 = (AW+2)'(npm1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_tready_1cyc", 64'(s_axis_tready), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
  endtask

  // Called right after the final beat handshake: DONE for one cycle, then done pulses.
  task automatic finish_load(input int prev_done);
    @(negedge clk);
    chk("done_state_done_low", 64'(done), 64'd0);
    chk("done_state_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 64'(prev_done + 1));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_load(input int npm1, input logic [31:0] tag, input int gap_mode, input int bad_beat);
    int total;
    int prev;
    logic last;
    int gaps;
    prev  = done_cnt;
    total = (npm1 + 1) * 16;
    do_start(npm1);
    for (int j = 0; j < total; j++) begin
      if (bad_beat >= 0) last = (j == bad_beat);
      else               last = (j == total - 1);
      gaps = 0;
      if (gap_mode != 0) gaps = (j % 3 == 1) ? 1 : ((j % 7 == 0) ? 2 : 0);
      send(j, {tag, 32'(j)}, last, gaps);
    end
    finish_load(prev);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst           = 1'b1;
    start         = 1'b0;
    num_pairs_m1  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ena", uram_ena, 64'd0);
    chk("rst_wea", uram_wea, 64'd0);
    chk("rst_addr", 64'(uram_addra), 64'd0);
    chk("rst_dina", uram_dina, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_tlast_err", 64'(tlast_err), 64'd0);
    @(posedge clk);
    #1;

    // 1: single row-pair, tdata = beat index
    do_start(0);
    prev = done_cnt;
    for (int j = 0; j < 16; j++) send(j, 64'(j), (j == 15), 0);
    finish_load(prev);
    chk("t1_tlast_err", 64'(tlast_err), 64'd0);
    chk("t1_write_count", 64'(log_ena.size()), 64'd16);
    chk("t1_first_ena", log_ena[0], 64'h0000_0000_0000_0001);
    chk("t1_last_ena", log_ena[15], 64'h0000_0000_0000_8000);

    // 2: eight row-pairs back to back
    log_ena.delete();
    log_addr.delete();
    run_load(7, 32'hA5A5_0002, 0, -1);
    chk("t2_write_count", 64'(log_ena.size()), 64'd128);
    chk("t2_pair5_ena", log_ena[80], 64'h0000_0000_0001_0000);
    chk("t2_pair5_addr", 64'(log_addr[80]), 64'd1);
    chk("t2_pair7_ena", log_ena[112], 64'h0001_0000_0000_0000);
    chk("t2_pair7_addr", 64'(log_addr[112]), 64'd1);
    chk("t2_pair7_last_ena", log_ena[127], 64'h8000_0000_0000_0000);
    chk("t2_pair3_addr", 64'(log_addr[63]), 64'd0);
    chk("t2_tlast_err", 64'(tlast_err), 64'd0);

    // 3: same load with tvalid gaps
    log_ena.delete();
    log_addr.delete();
    run_load(7, 32'h5A5A_0003, 1, -1);
    chk("t3_write_count", 64'(log_ena.size()), 64'd128);
    chk("t3_pair5_ena", log_ena[80], 64'h0000_0000_0001_0000);
    chk("t3_pair7_addr", 64'(log_addr[112]), 64'd1);

    // 4: tlast early on beat 3, missing on beat 15
    run_load(0, 32'hC0DE_0004, 0, 3);
    chk("t4_tlast_err_sticky", 64'(tlast_err), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_tlast_err_held", 64'(tlast_err), 64'd1);

    // 5: reset after 20 beats of a 4-pair load
    do_start(3);
    chk("t5_start_clears_err", 64'(tlast_err), 64'd0);
    prev = done_cnt;
    for (int j = 0; j < 20; j++) send(j, {32'hBEEF_0005, 32'(j)}, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_ena", uram_ena, 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_tready", 64'(s_axis_tready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_done", 64'(done_cnt), 64'(prev));
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    log_ena.delete();
    log_addr.delete();
    run_load(0, 32'hF00D_0005, 0, -1);
    chk("t5_fresh_ena", log_ena[0], 64'h0000_0000_0000_0001);
    chk("t5_fresh_addr", 64'(log_addr[0]), 64'd0);

    // 6: start with a smaller count mid-load must be ignored
    do_start(1);
    prev = done_cnt;
    for (int j = 0; j < 5; j++) send(j, {32'h6666_0006, 32'(j)}, 1'b0, 0);
    start        = 1'b1;
    num_pairs_m1 = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 5; j < 32; j++) send(j, {32'h6666_0006, 32'(j)}, (j == 31), 0);
    finish_load(prev);
    chk("t6_tlast_err", 64'(tlast_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
